// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier datapath and its control.
// Holds the default operand width, the derived register widths and the command decode.
package mul_pkg;

  localparam int MUL_WIDTH = 4;
  localparam int ACC_W     = 2*MUL_WIDTH+1;
  localparam int CNT_W     = $clog2(MUL_WIDTH+1);

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_SH   = 2'd2,
    CMD_AD   = 2'd3
  } cmd_e;

  // Load beats Sh beats Ad; losers in the same cycle are dropped.
  function automatic cmd_e decode_cmd(input logic load, input logic sh, input logic ad);
    if (load) return CMD_LOAD;
    if (sh)   return CMD_SH;
    if (ad)   return CMD_AD;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/mul_shift_counter.sv
// Shift counter: loads WIDTH on a new operation, counts shifts down to zero and then sticks.
// Flags are combinational from the count register; updates take effect on the next edge.
module mul_shift_counter #(
  parameter int WIDTH = mul_pkg::MUL_WIDTH,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CNT_W'(WIDTH);
    else if (dec_i && !zero_o)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath driven by Load/Sh/Ad commands from an external control.
// Product registers at the edge of the final shift; Done pulses the cycle after, for one cycle.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Load,
  input  logic               Sh,
  input  logic               Ad,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  output logic               K,
  output logic               M,
  output logic [2*WIDTH-1:0] Product,
  output logic               Done
);

  localparam int AW = 2*WIDTH+1;
  localparam int CW = $clog2(WIDTH+1);

  logic [AW-1:0]      acc_q, acc_d, acc_shr;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum;
  logic               cnt_last;
  cmd_e               cmd;

  assign cmd     = decode_cmd(Load, Sh, Ad);
  assign acc_shr = acc_q >> 1;
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};

  mul_shift_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CW)
  ) u_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load_i  (cmd == CMD_LOAD),
    .dec_i   (cmd == CMD_SH),
    .zero_o  (K),
    .last_o  (cnt_last)
  );

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (cmd)
      // The multiplier LSB is folded into the load so the control starts with a shift.
      CMD_LOAD: begin
        mcand_d = Mcand;
        acc_d   = {1'b0, (Mplier[0] ? Mcand : {WIDTH{1'b0}}), Mplier};
      end
      CMD_SH: begin
        if (!K) begin
          acc_d = acc_shr;
          if (cnt_last) begin
            product_d = acc_shr[2*WIDTH-1:0];
            done_d    = 1'b1;
          end
        end
      end
      CMD_AD: begin
        if (!K) acc_d[AW-1:WIDTH] = sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign M       = acc_q[0];
  assign Product = product_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_mul_datapath.sv
// Scoreboarded bench: a paired-control driver issues operations, a negedge monitor checks each Done.
// Expected products and Done cycles come from plain multiplication and bit counting.
module tb_mul_datapath;

  localparam int W = 4;

  logic           Clk     = 1'b0;
  logic           Reset_n = 1'b1;
  logic           Load    = 1'b0;
  logic           Sh      = 1'b0;
  logic           Ad      = 1'b0;
  logic [W-1:0]   Mplier  = '0;
  logic [W-1:0]   Mcand   = '0;
  logic           K, M, Done;
  logic [2*W-1:0] Product;

  typedef struct {
    int prod;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc       = 0;
  int   errors    = 0;
  int   checks    = 0;
  int   last_prod = 0;

  mul_datapath #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Load    (Load),
    .Sh      (Sh),
    .Ad      (Ad),
    .Mplier  (Mplier),
    .Mcand   (Mcand),
    .K       (K),
    .M       (M),
    .Product (Product),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every Done must match the oldest outstanding operation.
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, Done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("product", {24'd0, Product}, mon_e.prod);
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Paired control; with conflict set, Load is issued together with Sh and the
  // first Ad is issued together with Sh, so that partial product is lost.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit conflict);
    logic [W-1:0] a_eff;
    bit   found, used, do_sh, fin;
    exp_t e;
    a_eff = a;
    found = 1'b0;
    used  = 1'b0;
    do_sh = 1'b1;
    fin   = 1'b0;
    if (conflict)
      for (int i = 1; i < W; i++)
        if (!found && a_eff[i]) begin
          a_eff[i] = 1'b0;
          found    = 1'b1;
        end
    @(posedge Clk);
    #1;
    Mplier = a;
    Mcand  = b;
    Load   = 1'b1;
    Sh     = conflict;
    e.prod = int'(a_eff) * int'(b);
    e.cyc  = cyc + 1 + W + $countones(a_eff[W-1:1]);
    sb.push_back(e);
    last_prod = e.prod;
    tick();
    Load   = 1'b0;
    Sh     = 1'b0;
    Mplier = W'($urandom);
    Mcand  = W'($urandom);
    for (int s = 0; s < 4*W && !fin; s++) begin
      if (do_sh) begin
        Sh = 1'b1;
        tick();
        Sh = 1'b0;
        if (K) fin = 1'b1;
        else   do_sh = !M;
      end else if (conflict && !used) begin
        Ad = 1'b1;
        Sh = 1'b1;
        tick();
        Ad   = 1'b0;
        Sh   = 1'b0;
        used = 1'b1;
        if (K) fin = 1'b1;
        else   do_sh = !M;
      end else begin
        Ad = 1'b1;
        tick();
        Ad    = 1'b0;
        do_sh = 1'b1;
      end
    end
    check("k_after_op", {31'd0, K}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 Reset_n = 1'b0;
    #2;
    check("reset_k", {31'd0, K}, 32'd1);
    check("reset_m", {31'd0, M}, 32'd0);
    check("reset_product", {24'd0, Product}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    @(posedge Clk);
    #3 Reset_n = 1'b1;

    run_op(4'd0, 4'd9, 1'b0);
    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd11, 4'd13, 1'b0);

    // Stray commands while idle must not disturb anything.
    tick();
    Sh = 1'b1;
    tick();
    tick();
    Sh = 1'b0;
    Ad = 1'b1;
    tick();
    Sh = 1'b1;
    tick();
    Sh = 1'b0;
    Ad = 1'b0;
    tick();
    check("stray_k", {31'd0, K}, 32'd1);
    check("stray_m", {31'd0, M}, last_prod & 1);
    check("stray_product", {24'd0, Product}, last_prod);

    // Abort 7x6 after its second shift.
    Mplier = 4'd7;
    Mcand  = 4'd6;
    Load   = 1'b1;
    tick();
    Load = 1'b0;
    Sh   = 1'b1;
    tick();
    Sh = 1'b0;
    Ad = 1'b1;
    tick();
    Ad = 1'b0;
    Sh = 1'b1;
    tick();
    Sh      = 1'b0;
    Reset_n = 1'b0;
    #1;
    check("abort_k", {31'd0, K}, 32'd1);
    check("abort_m", {31'd0, M}, 32'd0);
    check("abort_product", {24'd0, Product}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    tick();
    check("post_abort_product", {24'd0, Product}, 32'd0);
    run_op(4'd7, 4'd6, 1'b0);

    run_op(4'd11, 4'd13, 1'b1);
    run_op(4'd14, 4'd15, 1'b1);

    for (int n = 0; n < 20; n++)
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
